pipe_frame_acc: RTL and testbench

Downstream consumer of the (a±b)*c pipelined datapath. It takes the 16-bit product stream d, groups it into frames of FRAME_LEN samples and computes per-frame sum, max, min, sample count and frame id. Results are emitted through a one-entry output register with a valid/ready handshake, so accumulation of the next frame overlaps with the wait for the consumer. A flush input closes a partial frame early.

---
 rtl/pipe_acc_pkg.sv | 24 ++
 rtl/pipe_frame_stats.sv | 74 +++++++
 rtl/pipe_frame_acc.sv | 139 +++++++++++++
 tb/tb_pipe_frame_acc.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_acc_pkg.sv
// Shared constants, accumulator state encoding and frame-result layout
// for the per-frame statistics accumulator.
package pipe_acc_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned FRAME_LEN = 8;
    localparam int unsigned ACC_W     = 19;
    localparam int unsigned ID_W      = 8;
    localparam int unsigned LEN_W     = $clog2(FRAME_LEN) + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic [ACC_W-1:0]  sum;
        logic [DATA_W-1:0] max;
        logic [DATA_W-1:0] min;
        logic [LEN_W-1:0]  len;
        logic [ID_W-1:0]   id;
    } frame_res_t;

endpackage

// File: rtl/pipe_frame_stats.sv
// Running sum/max/min/count of the open frame; the _c outputs show the
// frame including this cycle's accepted sample, used when a frame closes.
module pipe_frame_stats
    import pipe_acc_pkg::*;
#(
    parameter int unsigned P_DATA_W = DATA_W,
    parameter int unsigned P_ACC_W  = ACC_W,
    parameter int unsigned P_LEN_W  = LEN_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_acc,
    input  logic                i_first,
    input  logic                i_clear,
    input  logic [P_DATA_W-1:0] i_data,
    output logic [P_LEN_W-1:0]  o_cnt,
    output logic [P_ACC_W-1:0]  o_sum_c,
    output logic [P_DATA_W-1:0] o_max_c,
    output logic [P_DATA_W-1:0] o_min_c,
    output logic [P_LEN_W-1:0]  o_cnt_c
);

    logic [P_ACC_W-1:0]  r_sum;
    logic [P_DATA_W-1:0] r_max;
    logic [P_DATA_W-1:0] r_min;
    logic [P_LEN_W-1:0]  r_cnt;

    logic [P_ACC_W-1:0]  w_sum;
    logic [P_DATA_W-1:0] w_max;
    logic [P_DATA_W-1:0] w_min;
    logic [P_LEN_W-1:0]  w_cnt;

    // Load on the first sample of a frame, otherwise fold the sample in.
    always_comb begin
        w_sum = r_sum;
        w_max = r_max;
        w_min = r_min;
        w_cnt = r_cnt;
        if (i_acc) begin
            if (i_first) begin
                w_sum = P_ACC_W'(i_data);
                w_max = i_data;
                w_min = i_data;
                w_cnt = P_LEN_W'(1);
            end else begin
                w_sum = r_sum + P_ACC_W'(i_data);
                w_max = (i_data > r_max) ? i_data : r_max;
                w_min = (i_data < r_min) ? i_data : r_min;
                w_cnt = r_cnt + P_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_sum <= '0;
            r_max <= '0;
            r_min <= '0;
            r_cnt <= '0;
        end else if (i_acc) begin
            r_sum <= w_sum;
            r_max <= w_max;
            r_min <= w_min;
            r_cnt <= w_cnt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_sum_c = w_sum;
    assign o_max_c = w_max;
    assign o_min_c = w_min;
    assign o_cnt_c = w_cnt;

endmodule

// File: rtl/pipe_frame_acc.sv
// Groups the product stream into frames and emits per-frame sum/max/min/len/id
// through a one-entry valid/ready output register; flush closes a partial frame.
module pipe_frame_acc
    import pipe_acc_pkg::*;
#(
    parameter int unsigned P_DATA_W    = DATA_W,
    parameter int unsigned P_FRAME_LEN = FRAME_LEN,
    parameter int unsigned P_ACC_W     = ACC_W,
    parameter int unsigned P_ID_W      = ID_W,
    parameter int unsigned P_LEN_W     = $clog2(P_FRAME_LEN) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [P_DATA_W-1:0] in_data,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [P_ACC_W-1:0]  out_sum,
    output logic [P_DATA_W-1:0] out_max,
    output logic [P_DATA_W-1:0] out_min,
    output logic [P_LEN_W-1:0]  out_len,
    output logic [P_ID_W-1:0]   out_id
);

    acc_state_e r_state;
    acc_state_e w_state_nxt;

    logic                r_flush_pend;
    logic                r_out_valid;
    logic [P_ACC_W-1:0]  r_out_sum;
    logic [P_DATA_W-1:0] r_out_max;
    logic [P_DATA_W-1:0] r_out_min;
    logic [P_LEN_W-1:0]  r_out_len;
    logic [P_ID_W-1:0]   r_out_id;
    logic [P_ID_W-1:0]   r_next_id;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_pop;
    logic                w_slot_free;
    logic                w_has_data;
    logic                w_full_close;
    logic                w_close;
    logic                w_pend_set;
    logic [P_LEN_W-1:0]  w_cnt;
    logic [P_ACC_W-1:0]  w_sum_c;
    logic [P_DATA_W-1:0] w_max_c;
    logic [P_DATA_W-1:0] w_min_c;
    logic [P_LEN_W-1:0]  w_cnt_c;

    pipe_frame_stats #(
        .P_DATA_W (P_DATA_W),
        .P_ACC_W  (P_ACC_W),
        .P_LEN_W  (P_LEN_W)
    ) u_stats (
        .clk     (clk),
        .reset   (reset),
        .i_acc   (w_accept),
        .i_first (r_state == IDLE),
        .i_clear (w_close),
        .i_data  (in_data),
        .o_cnt   (w_cnt),
        .o_sum_c (w_sum_c),
        .o_max_c (w_max_c),
        .o_min_c (w_min_c),
        .o_cnt_c (w_cnt_c)
    );

    // Stall only when the next sample would complete a frame that has nowhere to go.
    assign w_in_ready  = ~reset & ~(r_out_valid & (w_cnt == P_LEN_W'(P_FRAME_LEN - 1)));
    assign w_accept    = in_valid & w_in_ready;
    assign w_pop       = r_out_valid & out_ready;
    assign w_slot_free = ~r_out_valid | out_ready;
    assign w_has_data  = (w_cnt_c != '0);
    assign w_full_close = w_accept & (w_cnt_c == P_LEN_W'(P_FRAME_LEN));
    assign w_close     = w_full_close | ((flush | r_flush_pend) & w_has_data & w_slot_free);
    assign w_pend_set  = flush & w_has_data & ~w_slot_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_close) w_state_nxt = ACCUM;
            ACCUM:   if (w_close)              w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_pend <= 1'b0;
        end else if (w_close) begin
            r_flush_pend <= 1'b0;
        end else if (w_pend_set) begin
            r_flush_pend <= 1'b1;
        end
    end

    // Output slot: a closing frame may reload it in the same cycle it is popped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_max   <= '0;
            r_out_min   <= '0;
            r_out_len   <= '0;
            r_out_id    <= '0;
            r_next_id   <= '0;
        end else if (w_close) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum_c;
            r_out_max   <= w_max_c;
            r_out_min   <= w_min_c;
            r_out_len   <= w_cnt_c;
            r_out_id    <= r_next_id;
            r_next_id   <= r_next_id + P_ID_W'(1);
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_len   = r_out_len;
    assign out_id    = r_out_id;

endmodule

// File: tb/tb_pipe_frame_acc.sv
// Directed and random stimulus for pipe_frame_acc, checked every cycle against
// a queue-based frame model plus explicit expected values for key scenarios.
module tb_pipe_frame_acc;
    import pipe_acc_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [DATA_W-1:0] out_max;
    logic [DATA_W-1:0] out_min;
    logic [LEN_W-1:0]  out_len;
    logic [ID_W-1:0]   out_id;

    pipe_frame_acc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_len   (out_len),
        .out_id    (out_id)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_bad = 0;
    int         pop_idx = 0;
    int         closes = 0;
    bit         last_acc;

    // Model: samples of the open frame, the held result, pending flush, next id.
    int unsigned fq[$];
    bit          m_valid = 1'b0;
    frame_res_t  m_out = '0;
    bit          m_pend = 1'b0;
    int unsigned m_nid = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_close();
        int unsigned s;
        int unsigned mx;
        int unsigned mn;
        s  = 0;
        mx = 0;
        mn = 32'hFFFF_FFFF;
        foreach (fq[i]) begin
            s = s + fq[i];
            if (fq[i] > mx) mx = fq[i];
            if (fq[i] < mn) mn = fq[i];
        end
        m_out.sum = ACC_W'(s);
        m_out.max = DATA_W'(mx);
        m_out.min = DATA_W'(mn);
        m_out.len = LEN_W'(fq.size());
        m_out.id  = ID_W'(m_nid);
        m_nid     = (m_nid + 1) % (1 << ID_W);
        m_valid   = 1'b1;
        m_pend    = 1'b0;
        closes++;
        fq.delete();
    endtask

    // One clock: drive at the falling edge, check, advance the model at the rising edge.
    task automatic step(input bit rst, input bit v, input logic [DATA_W-1:0] d,
                        input bit f, input bit ordy);
        bit e_rdy;
        bit acc;
        bit pop;
        reset     = rst;
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = ordy;
        #1;
        e_rdy = !rst && !(m_valid && fq.size() == FRAME_LEN - 1);
        chk("in_ready",  32'(in_ready),  32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_sum",   32'(out_sum),   32'(m_out.sum));
        chk("out_max",   32'(out_max),   32'(m_out.max));
        chk("out_min",   32'(out_min),   32'(m_out.min));
        chk("out_len",   32'(out_len),   32'(m_out.len));
        chk("out_id",    32'(out_id),    32'(m_out.id));
        last_acc = in_valid && in_ready;
        if (!rst && out_valid && ordy) begin
            if (pop_idx == 255) chk("id_before_wrap", 32'(out_id), 32'd255);
            if (pop_idx == 256) chk("id_after_wrap",  32'(out_id), 32'd0);
            pop_idx++;
        end
        @(posedge clk);
        if (rst) begin
            fq.delete();
            m_valid = 1'b0;
            m_out   = '0;
            m_pend  = 1'b0;
            m_nid   = 0;
            pop_idx = 0;
        end else begin
            acc = v && e_rdy;
            pop = m_valid && ordy;
            if (acc) fq.push_back(32'(d));
            if (fq.size() == FRAME_LEN) begin
                model_close();
            end else if ((f || m_pend) && fq.size() > 0) begin
                if (!m_valid || ordy) model_close();
                else                  m_pend = 1'b1;
            end else if (pop) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int n_acc;
        int cyc;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        repeat (2) step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);

        // Full frame 1..8 with consumer always ready.
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b1);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_sum",   32'(out_sum),   32'd36);
        chk("full_max",   32'(out_max),   32'd8);
        chk("full_min",   32'(out_min),   32'd1);
        chk("full_len",   32'(out_len),   32'd8);
        chk("full_id",    32'(out_id),    32'd0);

        // All-ones samples: largest possible sum.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1);
        chk("max_sum", 32'(out_sum), 32'h7FFF8);
        chk("max_max", 32'(out_max), 32'hFFFF);
        chk("max_min", 32'(out_min), 32'hFFFF);
        chk("max_len", 32'(out_len), 32'd8);
        chk("max_id",  32'(out_id),  32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Backpressure: the consumer stalls while 20 samples are offered.
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
            if (last_acc) n_acc++;
        end
        chk("bp_accepted", 32'(n_acc),     32'd15);
        chk("bp_in_ready", 32'(in_ready),  32'd0);
        chk("bp_valid",    32'(out_valid), 32'd1);
        chk("bp_id",       32'(out_id),    32'd2);
        step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b1);
        step(1'b0, 1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        chk("bp_reload_valid", 32'(out_valid), 32'd1);
        chk("bp_reload_id",    32'(out_id),    32'd3);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Flush closes a three-sample frame on its last sample.
        step(1'b0, 1'b1, 16'd10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd20, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'd30, 1'b1, 1'b1);
        chk("flush_sum", 32'(out_sum), 32'd60);
        chk("flush_max", 32'(out_max), 32'd30);
        chk("flush_min", 32'(out_min), 32'd10);
        chk("flush_len", 32'(out_len), 32'd3);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        chk("flush_empty_ignored", 32'(out_valid), 32'd0);

        // Flush arriving while the slot is held is deferred until the pop.
        step(1'b0, 1'b1, 16'd99, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'd5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 16'd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pend_held_valid", 32'(out_valid), 32'd1);
        chk("pend_held_sum",   32'(out_sum),   32'd99);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("pend_close_valid", 32'(out_valid), 32'd1);
        chk("pend_close_sum",   32'(out_sum),   32'd12);
        chk("pend_close_len",   32'(out_len),   32'd2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Reset in the middle of a frame discards it and restarts ids.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DATA_W'(i + 3), 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h5555, 1'b0, 1'b0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b0, 1'b1);
        chk("rst_sum", 32'(out_sum), 32'd36);
        chk("rst_id",  32'(out_id),  32'd0);

        // Random traffic until the frame id has wrapped.
        cyc = 0;
        while (pop_idx < 260 && cyc < 30000) begin
            step(1'b0, ($urandom_range(3, 0) != 0), DATA_W'($urandom),
                 ($urandom_range(15, 0) == 0), ($urandom_range(3, 0) != 0));
            cyc++;
        end
        chk("wrap_reached", 32'(pop_idx >= 260), 32'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
